// File: rtl/gray_pixel_packer.sv
// rtl/gray_pixel_packer.sv - packs 8-bit gray pixels into 32-bit words behind a show-ahead FIFO
//
// Purpose: sits after the RGB565->gray converter. Four pixels form one word
// with the first pixel in [7:0]. Each frame is FRAME_PIXELS long, and the
// word that holds the final pixel of a frame carries word_last.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   frame_start         one-cycle pulse that starts a new frame
//   pixel_valid/gray    input pixel stream; pixel_ready is the accept signal
//   word_valid/data     output word stream (show-ahead); word_last marks the
//   word_last/ready     end of a frame
//   fifo_level          number of words held in the FIFO
//   frame_abort         one-cycle pulse: a frame_start cut a frame short
//   drop_count          pixels discarded while idle (saturating)
module gray_pixel_packer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pixel_valid,
  input  logic [7:0]                    pixel_gray,
  output logic                          pixel_ready,
  output logic                          word_valid,
  output logic [31:0]                   word_data,
  output logic                          word_last,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_abort,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  logic [0:0]       state_q, state_d;
  logic [31:0]      pack_q, pack_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             abort_q, abort_d;
  logic [15:0]      drop_q, drop_d;
  logic [32:0]      mem_q [FIFO_DEPTH];

  logic             fifo_full, xfer, pop, push, push_last;
  logic [31:0]      push_word, base_pack;
  logic [1:0]       base_idx;
  logic [CNT_W-1:0] base_cnt, new_cnt;

  always_comb begin
    fifo_full  = (level_q == FULL_LVL);
    // A frame_start in the same cycle makes the pixel pixel 0 of a live
    // frame. The pixel must then obey the FIFO back-pressure.
    pixel_ready = ((state_q == ST_IDLE) && !frame_start) || !fifo_full;
    xfer       = pixel_valid && pixel_ready;
    word_valid = (level_q != '0);
    pop        = word_valid && word_ready;

    // frame_start clears the frame context before this cycle's pixel is applied.
    base_pack = frame_start ? 32'd0 : pack_q;
    base_idx  = frame_start ? 2'd0 : idx_q;
    base_cnt  = frame_start ? '0 : cnt_q;
    new_cnt   = base_cnt + CNT_W'(1);
    // Bytes above base_idx are already zero because pack is cleared on each push.
    push_word = base_pack | ({24'd0, pixel_gray} << {base_idx, 3'b000});
    push_last = (new_cnt == LAST_CNT);

    state_d = state_q;
    pack_d  = pack_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    abort_d = 1'b0;
    push    = 1'b0;

    if (frame_start) begin
      state_d = ST_ACTIVE;
      pack_d  = 32'd0;
      idx_d   = 2'd0;
      cnt_d   = '0;
      abort_d = (state_q == ST_ACTIVE) && (cnt_q != '0);
    end

    if (xfer) begin
      if ((state_q == ST_ACTIVE) || frame_start) begin
        if (push_last) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          pack_d  = 32'd0;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (base_idx == 2'd3) begin
          push   = 1'b1;
          pack_d = 32'd0;
          idx_d  = 2'd0;
          cnt_d  = new_cnt;
        end else begin
          pack_d = push_word;
          idx_d  = base_idx + 2'd1;
          cnt_d  = new_cnt;
        end
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + (PTR_W+1)'(1);
    else if (!push && pop) level_d = level_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pack_q   <= 32'd0;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      abort_q  <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      pack_q   <= pack_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      abort_q  <= abort_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: an entry is visible only while level_q covers it.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_word};
  end

  assign word_data   = word_valid ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign word_last   = word_valid & mem_q[rd_ptr_q][32];
  assign fifo_level  = level_q;
  assign frame_abort = abort_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_gray_pixel_packer.sv
// tb/tb_gray_pixel_packer.sv - directed self-checking bench for gray_pixel_packer
module tb_gray_pixel_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // a_*: full-size frame instance, b_*: six-pixel frame instance
  logic        a_frame_start = 0, a_pixel_valid = 0, a_word_ready = 0;
  logic [7:0]  a_pixel_gray = 0;
  logic        a_pixel_ready, a_word_valid, a_word_last, a_frame_abort;
  logic [31:0] a_word_data;
  logic [4:0]  a_fifo_level;
  logic [15:0] a_drop_count;

  logic        b_frame_start = 0, b_pixel_valid = 0, b_word_ready = 0;
  logic [7:0]  b_pixel_gray = 0;
  logic        b_pixel_ready, b_word_valid, b_word_last, b_frame_abort;
  logic [31:0] b_word_data;
  logic [4:0]  b_fifo_level;
  logic [15:0] b_drop_count;

  int checks = 0;
  int errors = 0;

  gray_pixel_packer dut (
    .clock(clock), .reset(reset), .frame_start(a_frame_start),
    .pixel_valid(a_pixel_valid), .pixel_gray(a_pixel_gray), .pixel_ready(a_pixel_ready),
    .word_valid(a_word_valid), .word_data(a_word_data), .word_last(a_word_last),
    .word_ready(a_word_ready), .fifo_level(a_fifo_level), .frame_abort(a_frame_abort),
    .drop_count(a_drop_count)
  );

  gray_pixel_packer #(.FRAME_PIXELS(6)) dut6 (
    .clock(clock), .reset(reset), .frame_start(b_frame_start),
    .pixel_valid(b_pixel_valid), .pixel_gray(b_pixel_gray), .pixel_ready(b_pixel_ready),
    .word_valid(b_word_valid), .word_data(b_word_data), .word_last(b_word_last),
    .word_ready(b_word_ready), .fifo_level(b_fifo_level), .frame_abort(b_frame_abort),
    .drop_count(b_drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_word;
    int sent;

    // Reset state
    #1;
    chk("rst_pixel_ready", 32'(a_pixel_ready), 32'd1);
    chk("rst_word_valid",  32'(a_word_valid),  32'd0);
    chk("rst_word_data",   a_word_data,        32'd0);
    chk("rst_word_last",   32'(a_word_last),   32'd0);
    chk("rst_fifo_level",  32'(a_fifo_level),  32'd0);
    chk("rst_frame_abort", 32'(a_frame_abort), 32'd0);
    chk("rst_drop_count",  32'(a_drop_count),  32'd0);
    tick();
    reset = 1'b0;

    // 1) four pixels back-to-back -> 0x44332211
    a_word_ready  = 1'b1;
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    a_pixel_valid = 1'b1;
    a_pixel_gray = 8'h11; tick();
    a_pixel_gray = 8'h22; tick();
    a_pixel_gray = 8'h33; tick();
    chk("t1_no_word_yet", 32'(a_word_valid), 32'd0);
    a_pixel_gray = 8'h44; tick();
    a_pixel_valid = 1'b0;
    chk("t1_word_valid", 32'(a_word_valid), 32'd1);
    chk("t1_word_data",  a_word_data,       32'h44332211);
    chk("t1_word_last",  32'(a_word_last),  32'd0);
    chk("t1_level",      32'(a_fifo_level), 32'd1);
    tick();
    chk("t1_popped", 32'(a_word_valid), 32'd0);

    // 5) frame_start after two pixels, then four fresh pixels
    a_pixel_valid = 1'b1;
    a_pixel_gray = 8'hAA; tick();
    a_pixel_gray = 8'hBB; tick();
    a_pixel_valid = 1'b0;
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    chk("t5_abort_pulse", 32'(a_frame_abort), 32'd1);
    chk("t5_no_partial",  32'(a_word_valid),  32'd0);
    a_word_ready = 1'b0;
    tick();
    chk("t5_abort_clear", 32'(a_frame_abort), 32'd0);
    a_pixel_valid = 1'b1;
    a_pixel_gray = 8'h01; tick();
    a_pixel_gray = 8'h02; tick();
    a_pixel_gray = 8'h03; tick();
    a_pixel_gray = 8'h04; tick();
    a_pixel_valid = 1'b0;
    chk("t5_word_data", a_word_data,       32'h04030201);
    chk("t5_level",     32'(a_fifo_level), 32'd1);
    tick();
    chk("t5_stable_data",  a_word_data,       32'h04030201);
    chk("t5_stable_valid", 32'(a_word_valid), 32'd1);
    a_word_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(a_fifo_level), 32'd0);

    // 3) back-pressure: 64 pixels with the consumer stalled
    a_word_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 64; cyc++) begin
      a_pixel_valid = 1'b1;
      a_pixel_gray  = 8'(sent);
      #0;
      if (a_pixel_ready) begin
        tick();
        sent++;
      end else begin
        tick();
      end
    end
    chk("t3_all_sent", 32'(sent), 32'd64);
    a_pixel_gray = 8'hFF;
    a_word_ready = 1'b1;
    #1;
    chk("t3_full_level", 32'(a_fifo_level),  32'd16);
    chk("t3_full_stall", 32'(a_pixel_ready), 32'd0);
    a_pixel_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_word = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      chk($sformatf("t3_word%0d_valid", i), 32'(a_word_valid), 32'd1);
      chk($sformatf("t3_word%0d_data", i),  a_word_data,       exp_word);
      tick();
    end
    chk("t3_empty", 32'(a_fifo_level), 32'd0);

    // 6) asynchronous reset with three words queued
    a_word_ready  = 1'b0;
    a_pixel_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_pixel_gray = 8'(8'h80 + i);
      tick();
    end
    a_pixel_valid = 1'b0;
    chk("t6_queued", 32'(a_fifo_level), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(a_word_valid), 32'd0);
    chk("t6_async_level", 32'(a_fifo_level), 32'd0);
    chk("t6_async_data",  a_word_data,       32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 4) pixels while idle are dropped
    b_pixel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_pixel_gray = 8'(8'h50 + i);
      #0;
      chk($sformatf("t4_ready%0d", i), 32'(b_pixel_ready), 32'd1);
      tick();
    end
    b_pixel_valid = 1'b0;
    chk("t4_drop_count", 32'(b_drop_count), 32'd5);
    chk("t4_no_words",   32'(b_word_valid), 32'd0);

    // 2) six-pixel frame: one full word plus a tail word tagged last
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    b_pixel_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      b_pixel_gray = 8'(i);
      tick();
      if (i == 4) begin
        chk("t2_first_valid", 32'(b_word_valid), 32'd1);
        chk("t2_first_data",  b_word_data,       32'h04030201);
      end
    end
    chk("t2_level", 32'(b_fifo_level), 32'd2);
    b_pixel_gray = 8'h77;
    tick();
    b_pixel_valid = 1'b0;
    chk("t2_idle_drop", 32'(b_drop_count), 32'd6);
    chk("t2_level_kept", 32'(b_fifo_level), 32'd2);
    b_word_ready = 1'b1;
    #1;
    chk("t2_w0_data", b_word_data,       32'h04030201);
    chk("t2_w0_last", 32'(b_word_last),  32'd0);
    tick();
    chk("t2_w1_data", b_word_data,       32'h00000605);
    chk("t2_w1_last", 32'(b_word_last),  32'd1);
    tick();
    chk("t2_empty", 32'(b_word_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
